vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Produces the pixel-coordinate stream (x, y) that the pixel colouring block consumes, and takes that block's registered 4-bit RGB back in.
- Drives the physical VGA pins: hsync, vsync and blanked RGB.
- Default timing is 640x480 at 60 Hz from a 25.175 MHz (nominally 25 MHz) pixel clock, with an 800x525 total raster.
- Sits between the board clock divider and the colouring logic; it is the only source of raster timing in the design.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low)
- PIXEL_LATENCY, 1, clocks from x/y to valid red_in/green_in/blue_in (range 0..4)

Ports:
- VGAclk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- red_in  in  4  colour returned by the colouring block
- green_in  in  4  colour returned by the colouring block
- blue_in  in  4  colour returned by the colouring block
- x  out  10  horizontal counter, 0..H_TOTAL-1
- y  out  10  vertical counter, 0..V_TOTAL-1
- hsync  out  1  horizontal sync pin
- vsync  out  1  vertical sync pin
- red  out  4  blanked colour to DAC
- green  out  4  blanked colour to DAC
- blue  out  4  blanked colour to DAC
- active  out  1  high when the output RGB is a visible pixel
- frame_start  out  1  one-clock pulse when x/y = (0,0)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL defined likewise (default 525). Both totals must be ≤ 1024; elaboration errors otherwise.
- Reset (asynchronous, immediate, including mid-frame):
  - x=0, y=0, red/green/blue=0, active=0, frame_start=0.
  - hsync/vsync = !SYNC_ACTIVE.
  - All delay-pipeline stages are cleared to these same idle values.
- Counters:
  - x increments every clock.
  - At x=H_TOTAL-1, x wraps to 0 and y increments.
  - At y=V_TOTAL-1 with x=H_TOTAL-1, both wrap to 0.
  - x and y are registered, and are presented over the full raster (not clamped to the active area).
- Horizontal region FSM, one-hot, advanced with x: H_ACT (x<H_ACTIVE) -> H_FRONT -> H_SYNCP -> H_BACK -> H_ACT.
  - Default boundaries: 640, 656, 752, 800.
- Vertical region FSM: V_ACT -> V_FRONT -> V_SYNCP -> V_BACK, advancing only on horizontal wrap.
  - Default boundaries: 480, 490, 492, 525.
- Raw signals in the x/y cycle:
  - hs_raw = (state==H_SYNCP), i.e. x 656..751.
  - vs_raw = (state==V_SYNCP), i.e. y 490..491.
  - de_raw = H_ACT && V_ACT.
- Alignment pipeline:
  - hs_raw, vs_raw and de_raw are delayed PIXEL_LATENCY clocks, then registered once more.
  - red_in/green_in/blue_in are registered once.
  - Outputs at cycle t therefore describe the coordinate presented at t-PIXEL_LATENCY-1. Default total latency = 2 clocks from x/y to pins.
- Outputs:
  - hsync = delayed hs_raw XNOR SYNC_ACTIVE.
  - vsync follows the same rule using delayed vs_raw.
  - active = delayed de_raw.
  - When active=0, red/green/blue are forced to 0 regardless of the inputs.
- frame_start: registered pulse, high for the single cycle in which x=0 and y=0 after a wrap.
  - Not asserted for the (0,0) held in reset or for the first cycle after release.
  - First pulse occurs H_TOTAL*V_TOTAL clocks after reset release.
- Input RGB is sampled every clock; there is no handshake. The colouring block must meet PIXEL_LATENCY exactly.

Optional Feature:
- Macro VGA_TESTPATTERN_EN.
- When defined:
  - Adds input port test_sel (1 bit).
  - While test_sel=1, the output RGB in active pixels is replaced by 8 vertical bars, each H_ACTIVE/8 wide (80 px default), indexed from the delayed x.
  - Bar order: white F/F/F, yellow F/F/0, cyan 0/F/F, green 0/F/0, magenta F/0/F, red F/0/0, blue 0/0/F, black 0/0/0 (values given as R/G/B).
  - test_sel is sampled with the same alignment as red_in.
  - Blanking and sync are unchanged.
- When undefined: no test_sel port, no bar logic; output RGB always derives from the inputs.

Test Plan:
1. Release reset, run 2 frames:
   - x wraps 799->0 and y increments on the same clock.
   - y wraps 524->0.
   - frame_start pulses exactly once, 420000 clocks after release, then every 420000 clocks.
2. Default parameters, PIXEL_LATENCY=1:
   - hsync is low for exactly 96 clocks per line, falling 2 clocks after x=656.
   - vsync is low for exactly 1600 clocks, starting 2 clocks after (x=0, y=490).
3. Drive red_in=4'hB only when the previous cycle's x=639, else 4'h3:
   - Output red=4'hB on the last active pixel.
   - red=0 on every blanked pixel.
   - active falls on the next clock.
4. Assert rst_n=0 at (x=300, y=200) for 3 clocks:
   - All outputs go to reset values immediately, asynchronously.
   - After release, counting resumes from (0,0) with no frame_start at (0,0).
5. PIXEL_LATENCY=3, with the colouring model delayed 3 clocks:
   - Colour edge at x=300 appears on the pins exactly 4 clocks after x=300, coincident with an unchanged active.
6. With VGA_TESTPATTERN_EN and test_sel=1:
   - Pixel x=80 outputs F/F/0.
   - x=639 outputs 0/0/0.
   - x=700 outputs 0/0/0 with active=0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters, region FSMs, sync/blank alignment (optional VGA_TESTPATTERN_EN colour bars)
module vga_timing_gen #(
    parameter int H_ACTIVE      = 640,
    parameter int H_FP          = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BP          = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FP          = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BP          = 33,
    parameter int SYNC_ACTIVE   = 0,
    parameter int PIXEL_LATENCY = 1
) (
    input  logic       VGAclk,
    input  logic       rst_n,
    input  logic [3:0] red_in,
    input  logic [3:0] green_in,
    input  logic [3:0] blue_in,
`ifdef VGA_TESTPATTERN_EN
    input  logic       test_sel,
`endif
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       active,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int STAGES  = PIXEL_LATENCY + 1;

    // Last coordinate of each region; the FSMs leave a region on these values.
    localparam logic [9:0] H_A_END = 10'(H_ACTIVE - 1);
    localparam logic [9:0] H_F_END = 10'(H_ACTIVE + H_FP - 1);
    localparam logic [9:0] H_S_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_A_END = 10'(V_ACTIVE - 1);
    localparam logic [9:0] V_F_END = 10'(V_ACTIVE + V_FP - 1);
    localparam logic [9:0] V_S_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);

    localparam logic SYNC_LVL = (SYNC_ACTIVE != 0);

    // Counters are 10 bits wide and every region must be at least one unit long.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (PIXEL_LATENCY < 0 || PIXEL_LATENCY > 4) begin : g_bad_latency
        $error("vga_timing_gen: PIXEL_LATENCY must be within 0..4");
    end
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_region
        $error("vga_timing_gen: every raster region must be at least 1 long");
    end

    typedef enum logic [3:0] {
        H_ACT   = 4'b0001,
        H_FRONT = 4'b0010,
        H_SYNCP = 4'b0100,
        H_BACK  = 4'b1000
    } h_state_t;

    typedef enum logic [3:0] {
        V_ACT   = 4'b0001,
        V_FRONT = 4'b0010,
        V_SYNCP = 4'b0100,
        V_BACK  = 4'b1000
    } v_state_t;

    logic [9:0]        r_x;
    logic [9:0]        r_y;
    h_state_t          r_h_state;
    h_state_t          w_h_next;
    v_state_t          r_v_state;
    v_state_t          w_v_next;
    logic              w_h_wrap;
    logic              w_v_wrap;
    logic              w_hs_raw;
    logic              w_vs_raw;
    logic              w_de_raw;
    logic [STAGES-1:0] r_hs_pipe;
    logic [STAGES-1:0] r_vs_pipe;
    logic [STAGES-1:0] r_de_pipe;
    logic [3:0]        r_red;
    logic [3:0]        r_green;
    logic [3:0]        r_blue;
    logic              r_frame_start;
    logic              w_active;
    logic [3:0]        w_red;
    logic [3:0]        w_green;
    logic [3:0]        w_blue;

    assign w_h_wrap = (r_x == H_LAST);
    assign w_v_wrap = (r_y == V_LAST);

    // Raster counters: x every clock, y on each horizontal wrap.
    always_ff @(posedge VGAclk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else begin
            r_x <= w_h_wrap ? 10'd0 : r_x + 10'd1;
            if (w_h_wrap) begin
                r_y <= w_v_wrap ? 10'd0 : r_y + 10'd1;
            end
        end
    end

    // Region state registers; reset lands in the active region matching (0,0).
    always_ff @(posedge VGAclk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_state <= H_ACT;
            r_v_state <= V_ACT;
        end else begin
            r_h_state <= w_h_next;
            r_v_state <= w_v_next;
        end
    end

    // Horizontal region transitions, taken on the last x of each region.
    always_comb begin
        w_h_next = r_h_state;
        case (r_h_state)
            H_ACT:   if (r_x == H_A_END) w_h_next = H_FRONT;
            H_FRONT: if (r_x == H_F_END) w_h_next = H_SYNCP;
            H_SYNCP: if (r_x == H_S_END) w_h_next = H_BACK;
            H_BACK:  if (w_h_wrap)       w_h_next = H_ACT;
            default: w_h_next = H_ACT;
        endcase
    end

    // Vertical region transitions, only evaluated on the horizontal wrap.
    always_comb begin
        w_v_next = r_v_state;
        if (w_h_wrap) begin
            case (r_v_state)
                V_ACT:   if (r_y == V_A_END) w_v_next = V_FRONT;
                V_FRONT: if (r_y == V_F_END) w_v_next = V_SYNCP;
                V_SYNCP: if (r_y == V_S_END) w_v_next = V_BACK;
                V_BACK:  if (w_v_wrap)       w_v_next = V_ACT;
                default: w_v_next = V_ACT;
            endcase
        end
    end

    assign w_hs_raw = (r_h_state == H_SYNCP);
    assign w_vs_raw = (r_v_state == V_SYNCP);
    assign w_de_raw = (r_h_state == H_ACT) && (r_v_state == V_ACT);

    // Delay sync/enable by the colouring latency plus the output register stage.
    always_ff @(posedge VGAclk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs_pipe <= '0;
            r_vs_pipe <= '0;
            r_de_pipe <= '0;
        end else begin
            r_hs_pipe[0] <= w_hs_raw;
            r_vs_pipe[0] <= w_vs_raw;
            r_de_pipe[0] <= w_de_raw;
            for (int i = 1; i < STAGES; i++) begin
                r_hs_pipe[i] <= r_hs_pipe[i-1];
                r_vs_pipe[i] <= r_vs_pipe[i-1];
                r_de_pipe[i] <= r_de_pipe[i-1];
            end
        end
    end

    // Returned colour is captured once, lining it up with the last sync stage.
    always_ff @(posedge VGAclk or negedge rst_n) begin
        if (!rst_n) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else begin
            r_red   <= red_in;
            r_green <= green_in;
            r_blue  <= blue_in;
        end
    end

    // Frame pulse lands in the cycle where the counters wrap to (0,0).
    always_ff @(posedge VGAclk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_h_wrap && w_v_wrap;
        end
    end

`ifdef VGA_TESTPATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0] w_bar;
    logic [2:0] r_bar_pipe [STAGES];
    logic       r_test_sel;

    // Bar index from the raw x; it travels down the same delay as sync.
    always_comb begin
        w_bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (r_x >= 10'(k * BAR_W)) w_bar = 3'(k);
        end
    end

    // Bar index delay line and test_sel capture (aligned like red_in).
    always_ff @(posedge VGAclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) r_bar_pipe[i] <= 3'd0;
            r_test_sel <= 1'b0;
        end else begin
            r_bar_pipe[0] <= w_bar;
            for (int i = 1; i < STAGES; i++) r_bar_pipe[i] <= r_bar_pipe[i-1];
            r_test_sel <= test_sel;
        end
    end
`endif

    assign w_active = r_de_pipe[STAGES-1];

    // Output colour: pass-through or bars, always forced to black while blanked.
    always_comb begin
        w_red   = r_red;
        w_green = r_green;
        w_blue  = r_blue;
`ifdef VGA_TESTPATTERN_EN
        // Bar order W,Y,C,G,M,R,B,K decodes to R=~b[1], G=~b[2], B=~b[0].
        if (r_test_sel) begin
            w_red   = {4{~r_bar_pipe[STAGES-1][1]}};
            w_green = {4{~r_bar_pipe[STAGES-1][2]}};
            w_blue  = {4{~r_bar_pipe[STAGES-1][0]}};
        end
`endif
        if (!w_active) begin
            w_red   = 4'h0;
            w_green = 4'h0;
            w_blue  = 4'h0;
        end
    end

    assign x           = r_x;
    assign y           = r_y;
    assign hsync       = r_hs_pipe[STAGES-1] ? SYNC_LVL : ~SYNC_LVL;
    assign vsync       = r_vs_pipe[STAGES-1] ? SYNC_LVL : ~SYNC_LVL;
    assign active      = w_active;
    assign red         = w_red;
    assign green       = w_green;
    assign blue        = w_blue;
    assign frame_start = r_frame_start;

endmodule
